// File: rtl/audio_frame_buffer.sv
// Line-oriented audio FIFO that serializes each stored line into SAMPLE_W-wide samples, lane 0 first.
// Optional sticky overflow/underflow flags are built when AFB_ERR_FLAGS_EN is defined.
module audio_frame_buffer #(
  parameter int unsigned LINE_W   = 512,
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned DEPTH    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LINE_W-1:0]         in_line,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SAMPLE_W-1:0]       out_sample,
  output logic                      out_last,
  output logic [$clog2(DEPTH):0]    count
`ifdef AFB_ERR_FLAGS_EN
  ,
  output logic                      ovf_err,
  output logic                      unf_err
`endif
);

  localparam int unsigned SPL    = LINE_W / SAMPLE_W;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned LANE_W = (SPL > 1) ? $clog2(SPL) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(SPL - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);

  // Storage is never cleared; only the control state below is reset.
  logic [SPL-1:0][SAMPLE_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LANE_W-1:0] lane;
  logic [CNT_W-1:0]  cnt_q;

  logic push;
  logic accept;
  logic lane_end;
  logic pop;

  assign in_ready   = (cnt_q != FULL_CNT);
  assign out_valid  = (cnt_q != '0);
  assign push       = in_valid && in_ready;
  assign accept     = out_valid && out_ready;
  assign lane_end   = (lane == LAST_LANE);
  assign pop        = accept && lane_end;

  assign out_sample = mem[rd_ptr][lane];
  assign out_last   = out_valid && lane_end;
  assign count      = cnt_q;

  // Line storage write port.
  always_ff @(posedge clk) begin
    if (push && !rst && !flush) begin
      mem[wr_ptr] <= in_line;
    end
  end

  // Pointers, lane and occupancy; pointer wrap is the natural PTR_W-bit rollover.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      lane   <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (accept) begin
        lane <= lane_end ? '0 : lane + LANE_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

`ifdef AFB_ERR_FLAGS_EN
  logic ever_pushed;

  // Sticky error flags; underflow only counts once data has been seen since the last clear.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ovf_err     <= 1'b0;
      unf_err     <= 1'b0;
      ever_pushed <= 1'b0;
    end else begin
      if (in_valid && !in_ready) begin
        ovf_err <= 1'b1;
      end
      if (out_ready && !out_valid && ever_pushed) begin
        unf_err <= 1'b1;
      end
      if (push) begin
        ever_pushed <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_audio_frame_buffer.sv
// Scoreboard bench for audio_frame_buffer: expected samples are queued per accepted line and
// checked in order as the DUT emits them; occupancy is derived from the queued sample count.
module tb_audio_frame_buffer;

  localparam int LINE_W   = 512;
  localparam int SAMPLE_W = 16;
  localparam int DEPTH    = 16;
  localparam int SPL      = LINE_W / SAMPLE_W;
  localparam int CNT_W    = $clog2(DEPTH) + 1;

  logic                clk = 1'b0;
  logic                rst;
  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [LINE_W-1:0]   in_line;
  logic                out_valid;
  logic                out_ready;
  logic [SAMPLE_W-1:0] out_sample;
  logic                out_last;
  logic [CNT_W-1:0]    count;
`ifdef AFB_ERR_FLAGS_EN
  logic                ovf_err;
  logic                unf_err;
`endif

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // Each entry: {is_last, sample}
  logic [SAMPLE_W:0] exp_q[$];
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;
  bit m_ever = 1'b0;

  audio_frame_buffer #(
    .LINE_W(LINE_W), .SAMPLE_W(SAMPLE_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_line(in_line),
    .out_valid(out_valid), .out_ready(out_ready), .out_sample(out_sample),
    .out_last(out_last), .count(count)
`ifdef AFB_ERR_FLAGS_EN
    , .ovf_err(ovf_err), .unf_err(unf_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Monitor: mid-cycle, compare outputs with the model, then apply the handshakes of the coming edge.
  always @(negedge clk) begin : monitor
    int mcnt;
    logic [SAMPLE_W:0] e;
    if (mon_en) begin
      mcnt = (exp_q.size() + SPL - 1) / SPL;
      chk("count", 32'(count), 32'(mcnt));
      chk("in_ready", 32'(in_ready), 32'(mcnt != DEPTH));
      chk("out_valid", 32'(out_valid), 32'(mcnt != 0));
      if (mcnt != 0) begin
        e = exp_q[0];
        chk("out_sample", 32'(out_sample), 32'(e[SAMPLE_W-1:0]));
        chk("out_last", 32'(out_last), 32'(e[SAMPLE_W]));
      end else begin
        chk("out_last_idle", 32'(out_last), 32'(0));
      end
`ifdef AFB_ERR_FLAGS_EN
      chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
      chk("unf_err", 32'(unf_err), 32'(m_unf));
`endif
      if (rst || flush) begin
        exp_q.delete();
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_ever = 1'b0;
      end else begin
        if (in_valid && mcnt == DEPTH) m_ovf = 1'b1;
        if (out_ready && mcnt == 0 && m_ever) m_unf = 1'b1;
        if (mcnt != 0 && out_ready) void'(exp_q.pop_front());
        if (in_valid && mcnt != DEPTH) begin
          m_ever = 1'b1;
          for (int k = 0; k < SPL; k++)
            exp_q.push_back({(k == SPL - 1), in_line[k*SAMPLE_W +: SAMPLE_W]});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic make_line(input int tag, output logic [LINE_W-1:0] l);
    for (int k = 0; k < SPL; k++)
      l[k*SAMPLE_W +: SAMPLE_W] = (k == 0) ? SAMPLE_W'(tag) : SAMPLE_W'($urandom);
  endtask

  task automatic drain(input int budget, input string name, output int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    logic [LINE_W-1:0] l;
    int n;
    int guard;
    bit acc;
    int maxc;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_line = '0;
    tick();
    mon_en = 1'b1;
    chk("rst_count", 32'(count), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_last", 32'(out_last), 32'(0));
    tick();
    rst = 1'b0;

    // One line with sample k = k+1, streamed back-to-back.
    for (int k = 0; k < SPL; k++) l[k*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(k + 1);
    in_line = l; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("first_valid", 32'(out_valid), 32'(1));
    chk("first_sample", 32'(out_sample), 32'(1));
    drain(200, "single_drain", n);
    chk("single_cycles", 32'(n), 32'(SPL));

    // Fill to capacity with the consumer stalled; the extra offer must be refused.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      make_line(i, l); in_line = l;
      tick();
    end
    in_valid = 1'b0;
    chk("full_count", 32'(count), 32'(DEPTH));
    chk("full_in_ready", 32'(in_ready), 32'(0));
`ifdef AFB_ERR_FLAGS_EN
    chk("full_ovf", 32'(ovf_err), 32'(1));
`endif
    drain(DEPTH * SPL + 50, "full_drain", n);

    // Push coinciding with the pop-completing accept at count 5.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      make_line(100 + i, l); in_line = l;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (SPL - 1) tick();
    make_line(200, l); in_line = l; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("pushpop_count", 32'(count), 32'(5));
    drain(6 * SPL + 50, "pushpop_drain", n);

    // 40 tagged lines with random consumer back-pressure, crossing the pointer wrap.
    maxc = 0; guard = 0;
    for (int ln = 0; ln < 40; ln++) begin
      make_line(ln, l); in_line = l; in_valid = 1'b1;
      do begin
        out_ready = 1'($urandom_range(0, 1));
        acc = in_ready;
        tick();
        guard++;
        if (int'(count) > maxc) maxc = int'(count);
      end while (!acc && guard < 8000);
    end
    in_valid = 1'b0;
    chk("stream_timeout", 32'(guard < 8000), 32'(1));
    drain(DEPTH * SPL + 50, "stream_drain", n);
    chk("stream_maxcount", 32'(maxc <= DEPTH), 32'(1));

    // Flush at lane 7 of the third line while a new line is offered.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      make_line(300 + i, l); in_line = l;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (2 * SPL + 7) tick();
    chk("pre_flush_sample", 32'(out_sample), 32'(exp_q[0][SAMPLE_W-1:0]));
    make_line(399, l); in_line = l;
    flush = 1'b1; in_valid = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("flush_count", 32'(count), 32'(0));
    chk("flush_out_valid", 32'(out_valid), 32'(0));
`ifdef AFB_ERR_FLAGS_EN
    chk("flush_ovf", 32'(ovf_err), 32'(0));
    chk("flush_unf", 32'(unf_err), 32'(0));
`endif

    // Reset mid-line, then one fresh line must start at lane 0.
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      make_line(400 + i, l); in_line = l;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) tick();
    rst = 1'b1; out_ready = 1'b0;
    tick();
    rst = 1'b0;
    for (int k = 0; k < SPL; k++) l[k*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(k + 100);
    in_line = l; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("rst_restart_count", 32'(count), 32'(1));
    chk("rst_restart_lane0", 32'(out_sample), 32'(100));
    drain(200, "rst_restart_drain", n);

    tick();
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
